// File: rtl/vga_pkg.sv
// vga_pkg: default VGA 640x480 timing, line/frame total helpers, sync bundle type and colour-bar palette.
package vga_pkg;
  localparam int DEF_CLK_DIV   = 4;
  localparam int DEF_H_ACTIVE  = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_ACTIVE  = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;
  localparam int DEF_FETCH_LAT = 1;
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } sync_bundle_t;
  localparam logic [0:7][11:0] BAR_COLORS = {
    12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000
  };
  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction
  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction
  function automatic logic [11:0] bar_color(input logic [2:0] idx);
    return BAR_COLORS[idx];
  endfunction
endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: DEPTH pixel-tick shift plus one output register, flushed to IDLE.
module vga_sync_delay
  import vga_pkg::*;
#(
  parameter int  DEPTH = 1,
  parameter type T     = sync_bundle_t,
  parameter T    IDLE  = T'(0)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic tick,
  input  T     din,
  output T     dout
);
  localparam int W  = $bits(T);
  localparam int PW = W * (DEPTH + 1);
  logic [PW-1:0] pipe;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pipe <= {(DEPTH + 1){IDLE}};
    else if (flush) pipe <= {(DEPTH + 1){IDLE}};
    else if (tick) pipe <= PW'({pipe, din});
  assign dout = pipe[PW-1 -: W];
endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA timing, framebuffer fetch coordinates and latency-aligned sync/blanking.
// Define VGA_TEST_PATTERN_EN to add the pattern_data colour-bar output.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int   CLK_DIV   = DEF_CLK_DIV,
  parameter int   H_ACTIVE  = DEF_H_ACTIVE,
  parameter int   H_FP      = DEF_H_FP,
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   H_BP      = DEF_H_BP,
  parameter int   V_ACTIVE  = DEF_V_ACTIVE,
  parameter int   V_FP      = DEF_V_FP,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BP      = DEF_V_BP,
  parameter int   FETCH_LAT = DEF_FETCH_LAT,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        pixel_tick,
  output logic        fetch_valid,
  output logic [9:0]  fetch_x,
  output logic [9:0]  fetch_y,
  output logic        hsync,
  output logic        vsync,
  output logic        display_enable,
  output logic        line_start,
  output logic        frame_start
`ifdef VGA_TEST_PATTERN_EN
  ,
  output logic [11:0] pattern_data
`endif
);
  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int HS_LO   = H_ACTIVE + H_FP;
  localparam int VS_LO   = V_ACTIVE + V_FP;
  localparam sync_bundle_t IDLE = '{hsync: ~SYNC_POL, vsync: ~SYNC_POL, de: 1'b0};
  logic [DW-1:0] div_cnt;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_wrap, v_wrap, active;
  sync_bundle_t  raw, dly;
  assign pixel_tick  = enable && (div_cnt == DW'(CLK_DIV - 1));
  assign h_wrap      = h_cnt == HW'(H_TOTAL - 1);
  assign v_wrap      = v_cnt == VW'(V_TOTAL - 1);
  assign active      = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
  assign line_start  = pixel_tick && (h_cnt == '0);
  assign frame_start = line_start && (v_cnt == '0);
  assign raw = '{
    hsync: (h_cnt >= HW'(HS_LO) && h_cnt <= HW'(HS_LO + H_SYNC - 1)) ? SYNC_POL : ~SYNC_POL,
    vsync: (v_cnt >= VW'(VS_LO) && v_cnt <= VW'(VS_LO + V_SYNC - 1)) ? SYNC_POL : ~SYNC_POL,
    de:    active
  };
  // fetch_* describe the pixel at the counters when the tick fires, then the counters advance
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {div_cnt, h_cnt, v_cnt, fetch_valid, fetch_x, fetch_y} <= '0;
    else if (!enable) {div_cnt, h_cnt, v_cnt, fetch_valid, fetch_x, fetch_y} <= '0;
    else begin
      div_cnt <= pixel_tick ? '0 : div_cnt + 1'b1;
      if (pixel_tick) begin
        h_cnt       <= h_wrap ? '0 : h_cnt + 1'b1;
        v_cnt       <= h_wrap ? (v_wrap ? '0 : v_cnt + 1'b1) : v_cnt;
        fetch_valid <= active;
        fetch_x     <= active ? 10'(h_cnt) : '0;
        fetch_y     <= active ? 10'(v_cnt) : '0;
      end
    end
  vga_sync_delay #(.DEPTH(FETCH_LAT), .T(sync_bundle_t), .IDLE(IDLE)) u_sync_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (!enable),
    .tick  (pixel_tick),
    .din   (raw),
    .dout  (dly)
  );
  assign hsync          = dly.hsync;
  assign vsync          = dly.vsync;
  assign display_enable = dly.de;
`ifdef VGA_TEST_PATTERN_EN
  logic [11:0] bar_raw, bar_dly;
  assign bar_raw = active ? bar_color(3'(h_cnt / HW'(H_ACTIVE / 8))) : 12'h000;
  vga_sync_delay #(.DEPTH(FETCH_LAT), .T(logic [11:0]), .IDLE(12'h000)) u_bar_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (!enable),
    .tick  (pixel_tick),
    .din   (bar_raw),
    .dout  (bar_dly)
  );
  assign pattern_data = display_enable ? bar_dly : 12'h000;
`endif
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: randomized enable/reset sequences checked against a pixel-index timing model.
module tb_vga_timing_ctrl;
  localparam int D  = 3;
  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6, VF = 1, VS = 2, VB = 1;
  localparam int L  = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic pixel_tick, fetch_valid, hsync, vsync, display_enable, line_start, frame_start;
  logic [9:0] fetch_x, fetch_y;
`ifdef VGA_TEST_PATTERN_EN
  logic [11:0] pattern_data;
  logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
`endif
  int vectors = 0, miscompares = 0, c = 0;
  always #5 clk = ~clk;
  vga_timing_ctrl #(
    .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .FETCH_LAT(L), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pixel_tick(pixel_tick),
    .fetch_valid(fetch_valid), .fetch_x(fetch_x), .fetch_y(fetch_y),
    .hsync(hsync), .vsync(vsync), .display_enable(display_enable),
    .line_start(line_start), .frame_start(frame_start)
`ifdef VGA_TEST_PATTERN_EN
    , .pattern_data(pattern_data)
`endif
  );
  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (c=%0d)", tag, obs, exp, c);
    end
  endtask
  task automatic pix(input int j, output int h, output int v);
    h = (j % FT) % HT;
    v = (j % FT) / HT;
  endtask
  // n ticks have completed after c enabled edges; fetch shows pixel n-1, sync pixel n-1-L
  task automatic check_all;
    int n, h, v;
    logic en_ok, tk, act, hs_e, vs_e, de_e;
    en_ok = enable && rst_n;
    n = en_ok ? c / D : 0;
    tk = en_ok && (c % D == D - 1);
    pix(n, h, v);
    check("pixel_tick", 12'(pixel_tick), 12'(tk));
    check("line_start", 12'(line_start), 12'(tk && h == 0));
    check("frame_start", 12'(frame_start), 12'(tk && h == 0 && v == 0));
    pix(n - 1, h, v);
    act = n >= 1 && h < HA && v < VA;
    check("fetch_valid", 12'(fetch_valid), 12'(act));
    check("fetch_x", 12'(fetch_x), act ? 12'(h) : 12'h0);
    check("fetch_y", 12'(fetch_y), act ? 12'(v) : 12'h0);
    pix(n - 1 - L, h, v);
    hs_e = !(n - 1 - L >= 0 && h >= HA + HF && h < HA + HF + HS);
    vs_e = !(n - 1 - L >= 0 && v >= VA + VF && v < VA + VF + VS);
    de_e = n - 1 - L >= 0 && h < HA && v < VA;
    check("hsync", 12'(hsync), 12'(hs_e));
    check("vsync", 12'(vsync), 12'(vs_e));
    check("display_enable", 12'(display_enable), 12'(de_e));
`ifdef VGA_TEST_PATTERN_EN
    check("pattern_data", pattern_data, de_e ? bars[h / (HA / 8)] : 12'h000);
`endif
  endtask
  task automatic step;
    @(posedge clk);
    c = (enable && rst_n) ? c + 1 : 0;
    @(negedge clk);
    check_all;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check_all;
    rst_n = 1'b1;
    repeat (2) step;
    enable = 1'b1;
    repeat (D * FT + 2 * D * HT) step;
    for (int s = 0; s < 8; s++) begin
      enable = 1'b0;
      repeat ($urandom_range(1, 4)) step;
      enable = 1'b1;
      repeat ($urandom_range(20, D * FT)) step;
    end
    repeat ($urandom_range(50, 400)) step;
    #1 rst_n = 1'b0;
    c = 0;
    #1 check_all;
    @(negedge clk);
    check_all;
    rst_n = 1'b1;
    repeat (D * FT + D * HT) step;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
